req_encoder_8to3: RTL and testbench



---
 rtl/enc_pkg.sv | 23 ++
 rtl/prio_enc8.sv | 32 +++
 rtl/req_encoder_8to3.sv | 93 +++++++++
 tb/tb_req_encoder_8to3.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths, FSM state type and popcount helper for the 8-to-3 request encoder.
package enc_pkg;

  localparam int unsigned N_IN   = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // Number of set bits in an 8-bit vector (0..8).
  function automatic logic [CNT_W-1:0] popcount8(input logic [N_IN-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder.
//   vec      : input vector
//   idx      : index of the winning set bit (0 when vec is zero)
//   nonzero  : vec has at least one set bit
// PRIORITY_HIGH=1 selects the highest set index, 0 the lowest.
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [N_IN-1:0]   vec,
  output logic [CODE_W-1:0] idx,
  output logic              nonzero
);

  // Later loop iterations override earlier ones, so scan order sets priority.
  always_comb begin
    idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = int'(N_IN) - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

  assign nonzero = |vec;

endmodule

// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 encoder: accepts a multi-hot request vector and emits the
// index of every set bit, one code per handshake, in priority order.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : request vector handshake, vector on req_bits
//   code_valid/code_ready  : code handshake
//   code                   : current highest-priority pending index
//   code_last              : current code is the final one of the vector
//   pending_cnt            : bits still pending (0 in IDLE)
//   empty_req              : one-cycle pulse after an all-zero vector is accepted
module req_encoder_8to3
  import enc_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_IN-1:0]   req_bits,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_last,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              empty_req
);

  enc_state_t          state, state_nxt;
  logic [N_IN-1:0]     pending, pending_nxt;
  logic                empty_nxt;
  logic [CODE_W-1:0]   enc_idx;
  logic                enc_nz;
  logic [CNT_W-1:0]    pend_pop;
  logic                in_emit;

  prio_enc8 #(
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) u_prio (
    .vec    (pending),
    .idx    (enc_idx),
    .nonzero(enc_nz)
  );

  assign pend_pop = popcount8(pending);
  assign in_emit  = (state == EMIT);

  // State, pending vector and empty pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      empty_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      empty_req <= empty_nxt;
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    empty_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bits != '0) begin
            pending_nxt = req_bits;
            state_nxt   = EMIT;
          end else begin
            empty_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (code_ready) begin
          pending_nxt = pending & ~(N_IN'(1) << enc_idx);
          if (pend_pop == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode purely from registered state, so they hold under backpressure.
  assign req_ready   = ~in_emit;
  assign code_valid  = in_emit & enc_nz;
  assign code        = in_emit ? enc_idx : '0;
  assign pending_cnt = in_emit ? pend_pop : '0;
  assign code_last   = in_emit & (pend_pop == CNT_W'(1));

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Bench for req_encoder_8to3: high- and low-priority instances driven in lockstep,
// expected codes queued at acceptance and checked at each code handshake.
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_bits;
  logic       code_ready;

  logic       rdy_h, cv_h, last_h, emp_h;
  logic [2:0] code_h;
  logic [3:0] cnt_h;
  logic       rdy_l, cv_l, last_l, emp_l;
  logic [2:0] code_l;
  logic [3:0] cnt_l;

  always #5 clk = ~clk;

  req_encoder_8to3 #(.PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_h),
    .req_bits(req_bits), .code_valid(cv_h), .code_ready(code_ready),
    .code(code_h), .code_last(last_h), .pending_cnt(cnt_h), .empty_req(emp_h)
  );

  req_encoder_8to3 #(.PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_l),
    .req_bits(req_bits), .code_valid(cv_l), .code_ready(code_ready),
    .code(code_l), .code_last(last_l), .pending_cnt(cnt_l), .empty_req(emp_l)
  );

  typedef struct packed {
    logic [2:0] ch;
    logic [2:0] cl;
    logic       last;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0]  bits;
    int          n;
    logic [23:0] hi;   // first code in [2:0]
    logic [23:0] lo;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec3to8(input logic [2:0] c);
    return 8'(1) << c;
  endfunction

  // Scoreboard: pop and compare at every code handshake.
  always @(negedge clk) begin
    if (!rst && cv_h && code_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_code", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("code_hi", int'(code_h), int'(e.ch));
        chk("code_lo", int'(code_l), int'(e.cl));
        chk("last_hi", int'(last_h), int'(e.last));
        chk("last_lo", int'(last_l), int'(e.last));
        chk("cnt_hi",  int'(cnt_h),  int'(e.cnt));
        chk("cnt_lo",  int'(cnt_l),  int'(e.cnt));
        chk("cv_lo",   int'(cv_l),   1);
      end
    end
  end

  task automatic send(input logic [7:0] bits, input logic [23:0] hi,
                      input logic [23:0] lo, input int n);
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_bits  = bits;
    t = 0;
    while (!rdy_h && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) chk("req_ready_timeout", 0, 1);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.ch   = hi[3*k +: 3];
      e.cl   = lo[3*k +: 3];
      e.last = (k == n - 1);
      e.cnt  = 4'(n - k);
      q.push_back(e);
    end
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("latency_cv", int'(cv_h), int'(n != 0));
    if (n == 0) begin
      chk("empty_pulse_hi", int'(emp_h), 1);
      chk("empty_pulse_lo", int'(emp_l), 1);
      @(negedge clk);
      chk("empty_drop", int'(emp_h), 0);
      chk("empty_cv", int'(cv_h), 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t == 100) chk("drain_timeout", 0, 1);
    @(negedge clk);
    chk("idle_ready_hi", int'(rdy_h), 1);
    chk("idle_ready_lo", int'(rdy_l), 1);
    chk("idle_cv", int'(cv_h), 0);
    chk("idle_cnt", int'(cnt_h), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    int t;
    tbl[0] = '{8'hA4, 3, {15'd0, 3'd2, 3'd5, 3'd7}, {15'd0, 3'd7, 3'd5, 3'd2}};
    tbl[1] = '{8'h01, 1, 24'd0, 24'd0};
    tbl[2] = '{8'h00, 0, 24'd0, 24'd0};
    tbl[3] = '{8'h81, 2, {18'd0, 3'd0, 3'd7}, {18'd0, 3'd7, 3'd0}};
    tbl[4] = '{8'h18, 2, {18'd0, 3'd3, 3'd4}, {18'd0, 3'd4, 3'd3}};
    tbl[5] = '{8'hFF, 8,
               {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
               {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};

    rst = 1'b1; req_valid = 1'b0; req_bits = 8'h00; code_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(rdy_h), 1);
    chk("rst_cv", int'(cv_h), 0);
    chk("rst_code", int'(code_h), 0);
    chk("rst_last", int'(last_h), 0);
    chk("rst_cnt", int'(cnt_h), 0);
    chk("rst_empty", int'(emp_h), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].bits, tbl[i].hi, tbl[i].lo, tbl[i].n);
      drain();
    end

    // Backpressure: 0x90 held for three cycles.
    code_ready = 1'b0;
    send(8'h90, {18'd0, 3'd4, 3'd7}, {18'd0, 3'd7, 3'd4}, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_code_hi", int'(code_h), 7);
      chk("bp_code_lo", int'(code_l), 4);
      chk("bp_cnt", int'(cnt_h), 2);
      chk("bp_last", int'(last_h), 0);
      chk("bp_ready", int'(rdy_h), 0);
    end
    @(posedge clk); #1 code_ready = 1'b1;
    drain();

    // Reset after the second code of 0xFF.
    send(tbl[5].bits, tbl[5].hi, tbl[5].lo, 8);
    t = 0;
    while (q.size() > 6 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (t == 50) chk("mid_rst_timeout", 0, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_held_cnt", int'(cnt_h), 6);
    @(negedge clk);
    chk("mid_rst_cv", int'(cv_h), 0);
    chk("mid_rst_ready", int'(rdy_h), 1);
    chk("mid_rst_cnt", int'(cnt_h), 0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_code", int'(cv_h), 0);
    end
    send(8'h08, 24'd3, 24'd3, 1);
    drain();

    // Round trip through a 3-to-8 decoder for every one-hot vector.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'(1) << i;
      code_ready = 1'b0;
      send(v, 24'(i), 24'(i), 1);
      chk("rt_hi", int'(dec3to8(code_h)), int'(v));
      chk("rt_lo", int'(dec3to8(code_l)), int'(v));
      @(posedge clk); #1 code_ready = 1'b1;
      drain();
    end

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
